// File: rtl/and_bist_pkg.sv
// ============================================================================
//  and_bist_pkg : shared state encoding and polynomial constants for AND BIST
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package and_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  // MISR x^16+x^12+x^5+1, shift-left form: feedback taps sig[15], sig[11], sig[4]
  localparam int          MISR_W        = 16;
  localparam logic [15:0] MISR_TAP_MASK = 16'h8810;

  // LFSR x^8+x^6+x^5+x^4+1, shift-left form: feedback taps bits 7, 5, 4, 3
  localparam int          LFSR_W        = 8;
  localparam logic [7:0]  LFSR_TAP_MASK = 8'hB8;

  function automatic logic misr_fb(input logic [MISR_W-1:0] sig);
    return ^(sig & MISR_TAP_MASK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bist_lfsr.sv
// ============================================================================
//  bist_lfsr : 8-bit Fibonacci LFSR with load/enable and a nonzero-seed guard
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module bist_lfsr
  import and_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 8'hA5,
  parameter int                OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] state_o
);

  // An all-zero state would lock the register up, so it is never loaded.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? 8'h01 : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED_SAFE;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAP_MASK)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/and_gate_bist.sv
// ============================================================================
//  and_gate_bist : self-test of a 2-input AND gate with error count and MISR
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module and_gate_bist
  import and_bist_pkg::*;
#(
  parameter int          N_PATTERNS = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [15:0] MISR_SEED  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        dut_a,
  output logic        dut_b,
  input  logic        dut_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] signature
);

  localparam int                IDX_W = $clog2(N_PATTERNS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_PATTERNS - 1);

  bist_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic [7:0]        err_q, err_d;
  logic [MISR_W-1:0] sig_q, sig_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              lfsr_load;
  logic              lfsr_en;
  logic [1:0]        lfsr_pat;
  logic              exp_y;

  bist_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (2)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .en_i    (lfsr_en),
    .state_o (lfsr_pat)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    err_d     = err_q;
    sig_d     = sig_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    exp_y     = a_q & b_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          idx_d     = '0;
          err_d     = '0;
          sig_d     = MISR_SEED;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else if (state_q == DONE && !done_q) begin
          // Result is published one cycle after the last compare settles.
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == 8'd0);
        end
      end
      DRIVE: begin
        if (32'(idx_q) < 32'd4) begin
          {a_d, b_d} = idx_q[1:0];
        end else begin
          {a_d, b_d} = lfsr_pat;
          lfsr_en    = 1'b1;
        end
        state_d = SAMPLE;
      end
      SAMPLE: begin
        // Case-equality so an X on the gate output is scored as a miss.
        if ((dut_y !== exp_y) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        sig_d = {sig_q[MISR_W-2:0], misr_fb(sig_q)} ^ {13'b0, a_q, b_q, dut_y};
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      sig_q   <= MISR_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign signature = sig_q;

endmodule

`default_nettype wire
